rvga_pipe_ctrl: RTL and testbench
=================================

Name: rvga_pipe_ctrl

Overview:
Parametrised pipeline control unit for the rvga in-order core, generalising the fixed six-stage stall/flush logic to STAGES stages. It generates per-stage stall and flush vectors from memory handshakes, branch-occupancy and branch-resolution signals. It adds a debug halt/single-step state machine and wrapping cycle, retire and stall performance counters. It sits beside the stage chain in the core top and drives every stage's stall_v_i/flush_v_i.

Parameters:
STAGES, 6, number of pipeline stages; stage 0 is ifetch, stage STAGES-1 is writeback/retire (legal 3..16)
CNT_W, 32, width of each performance counter (legal 8..64)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
imem_req_v_i  in  1  ifetch has an outstanding instruction request
imem_resp_v_i  in  1  instruction data valid this cycle
dmem_req_v_i  in  1  memory stage issuing a data read or write
dmem_resp_v_i  in  1  data response valid this cycle
stage_v_i  in  STAGES  per-stage valid bit of the instruction held in each stage
br_v_i  in  STAGES  per-stage "holds control-transfer instruction"
btaken_i  in  1  resolve stage (STAGES-1) redirects the PC this cycle
dbg_halt_i  in  1  level: request halt / remain halted
dbg_step_i  in  1  pulse: execute one instruction while halted
stall_v_o  out  STAGES  per-stage hold
flush_v_o  out  STAGES  per-stage clear-valid (bubble insert)
retire_v_o  out  1  instruction retires this cycle
halted_o  out  1  core halted, pipeline empty
cycle_cnt_o  out  CNT_W  cycles since reset
instret_cnt_o  out  CNT_W  retired instructions
stall_cnt_o  out  CNT_W  cycles with stage 0 stalled while in RUN

Behaviour:
- stall_v_o, flush_v_o and retire_v_o are combinational from the inputs and registered state. Counters, the FSM and halted_o are registered.
- Reset (sync, rst_i high at posedge): FSM to RUN, counters to 0, halted_o 0.
- While rst_i is high: stall_v_o all 0, flush_v_o all 1, retire_v_o 0.
- dwait = dmem_req_v_i & ~dmem_resp_v_i. iwait = imem_req_v_i & ~imem_resp_v_i.
- redirect = btaken_i & ~dwait.
- brpend = OR of br_v_i[1..STAGES-1] & stage_v_i[1..STAGES-1].
- fe_hold = iwait | brpend | (state != RUN & ~step_grant).
- Priority 1, dwait: stall_v_o all 1, flush_v_o all 0. Redirect is ignored and retried.
- Priority 2, redirect: flush_v_o[0..STAGES-2] = 1, flush_v_o[STAGES-1] = 0, stall_v_o all 0.
- Priority 3, fe_hold: stall_v_o[0] = 1, flush_v_o[1] = 1 (bubble into stage 1), all other bits 0.
- Otherwise: stall_v_o and flush_v_o are all 0.
- retire_v_o = stage_v_i[STAGES-1] & ~stall_v_o[STAGES-1].
- FSM transitions:
  - RUN: dbg_halt_i -> DRAIN.
  - DRAIN: stage 0 held (fe_hold true). When stage_v_i[1..STAGES-1] == 0 -> HALTED and set halted_o.
  - HALTED: ~dbg_halt_i -> RUN and clear halted_o. Otherwise dbg_step_i -> STEP and clear halted_o. Halt release beats step.
  - STEP: step_grant = 1 until the first cycle in which imem_resp_v_i & ~stall_v_o[0], then -> DRAIN.
- step_grant is 0 outside STEP. A redirect during STEP/DRAIN flushes normally; DRAIN then waits on the refetched path being empty.
- dbg_step_i outside HALTED is ignored. dbg_halt_i deasserted during DRAIN/STEP still completes the drain to HALTED, then leaves to RUN next cycle.
- Counters:
  - cycle_cnt increments every non-reset cycle.
  - instret_cnt increments on retire_v_o.
  - stall_cnt increments when stall_v_o[0] & state == RUN.
  - All wrap modulo 2^CNT_W with no saturation.
- Simultaneous dwait and iwait: dwait rule wins. After dmem_resp_v_i, iwait applies on the next evaluation.

Decomposition:
- Shared package rvga_types gains rvga_pipe_state_e (RUN, DRAIN, HALTED, STEP; 2-bit encoding) and the localparam for the default stage count.
- One natural sub-module: rvga_perf_counter (CNT_W-wide, sync reset, increment enable, wrap), instantiated three times.

Test Plan:
- Reset then idle with STAGES=6, no requests: stall_v_o = 6'b0, flush_v_o = 6'b0, cycle_cnt_o = 10 after 10 cycles, instret_cnt_o = 0.
- dmem_req_v_i held 3 cycles without resp, with stage_v_i[5]=1: stall_v_o = 6'h3F for 3 cycles, retire_v_o = 0, stall_cnt_o = 3. On resp, retire_v_o = 1 and instret_cnt_o increments.
- br_v_i[2] & stage_v_i[2] set, then btaken_i at writeback: stall_v_o[0] = 1 and flush_v_o[1] = 1 while pending. Redirect cycle gives flush_v_o = 6'h1F. btaken_i together with dwait gives flush_v_o = 0.
- dbg_halt_i with stages 1..5 valid, draining one per cycle: halted_o rises one cycle after stage_v_i[1..5] == 0. dbg_step_i admits exactly one fetch, then halted_o returns.
- CNT_W=8, run 300 cycles: cycle_cnt_o = 44 (wrap).
- Assert rst_i mid-STEP: next cycle state RUN, halted_o 0, counters 0, flush_v_o all 1 during reset.

Source files
------------

// File: rtl/rvga_types.sv
// Shared rvga core types: pipeline-control FSM states and default pipeline depth.
package rvga_types;

    localparam int unsigned RVGA_STAGES_DEF = 6;

    typedef enum logic [1:0] {
        PIPE_RUN    = 2'd0,
        PIPE_DRAIN  = 2'd1,
        PIPE_HALTED = 2'd2,
        PIPE_STEP   = 2'd3
    } rvga_pipe_state_e;

    // Mask selecting stages 1..n-1, i.e. everything behind ifetch.
    function automatic logic [15:0] upper_stage_mask(input int unsigned n);
        logic [15:0] m;
        m = 16'h0000;
        for (int unsigned i = 1; i < 16; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/rvga_perf_counter.sv
// Free-running wrapping event counter with synchronous reset and increment enable.
module rvga_perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: advance by one when enabled, wrapping naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/rvga_pipe_ctrl.sv
// Stall/flush generation, debug halt/step FSM and performance counters for the
// rvga in-order pipeline of STAGES stages.
module rvga_pipe_ctrl
    import rvga_types::*;
#(
    parameter int unsigned STAGES = RVGA_STAGES_DEF,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              imem_req_v_i,
    input  logic              imem_resp_v_i,
    input  logic              dmem_req_v_i,
    input  logic              dmem_resp_v_i,
    input  logic [STAGES-1:0] stage_v_i,
    input  logic [STAGES-1:0] br_v_i,
    input  logic              btaken_i,
    input  logic              dbg_halt_i,
    input  logic              dbg_step_i,
    output logic [STAGES-1:0] stall_v_o,
    output logic [STAGES-1:0] flush_v_o,
    output logic              retire_v_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  cycle_cnt_o,
    output logic [CNT_W-1:0]  instret_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [15:0]       UPPER_MASK_W = upper_stage_mask(STAGES);
    localparam logic [STAGES-1:0] UPPER_MASK   = UPPER_MASK_W[STAGES-1:0];

    rvga_pipe_state_e state_d, state_q;
    logic             halted_d, halted_q;

    logic dwait, iwait, redirect, brpend, upper_empty, step_grant, fe_hold;

    assign dwait       = dmem_req_v_i & ~dmem_resp_v_i;
    assign iwait       = imem_req_v_i & ~imem_resp_v_i;
    assign redirect    = btaken_i & ~dwait;
    assign brpend      = |(br_v_i & stage_v_i & UPPER_MASK);
    assign upper_empty = ~|(stage_v_i & UPPER_MASK);
    assign step_grant  = (state_q == PIPE_STEP);
    assign fe_hold     = iwait | brpend | ((state_q != PIPE_RUN) & ~step_grant);

    // Prioritised hold/bubble decode; a pending dmem wait defers any redirect.
    always_comb begin
        stall_v_o = '0;
        flush_v_o = '0;
        if (rst_i) begin
            flush_v_o = '1;
        end else if (dwait) begin
            stall_v_o = '1;
        end else if (redirect) begin
            flush_v_o             = '1;
            flush_v_o[STAGES-1]   = 1'b0;
        end else if (fe_hold) begin
            stall_v_o[0] = 1'b1;
            flush_v_o[1] = 1'b1;
        end else begin
            stall_v_o = '0;
            flush_v_o = '0;
        end
    end

    assign retire_v_o = ~rst_i & stage_v_i[STAGES-1] & ~stall_v_o[STAGES-1];

    // Debug FSM next state; release of halt takes precedence over a step pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PIPE_RUN: begin
                if (dbg_halt_i) begin
                    state_d = PIPE_DRAIN;
                end else begin
                    state_d = PIPE_RUN;
                end
            end
            PIPE_DRAIN: begin
                if (upper_empty) begin
                    state_d = PIPE_HALTED;
                end else begin
                    state_d = PIPE_DRAIN;
                end
            end
            PIPE_HALTED: begin
                if (!dbg_halt_i) begin
                    state_d = PIPE_RUN;
                end else if (dbg_step_i) begin
                    state_d = PIPE_STEP;
                end else begin
                    state_d = PIPE_HALTED;
                end
            end
            PIPE_STEP: begin
                if (imem_resp_v_i && !stall_v_o[0]) begin
                    state_d = PIPE_DRAIN;
                end else begin
                    state_d = PIPE_STEP;
                end
            end
            default: begin
                state_d = PIPE_RUN;
            end
        endcase
        halted_d = (state_d == PIPE_HALTED);
    end

    // FSM state and halted flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= PIPE_RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign halted_o = halted_q;

    rvga_perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (1'b1),
        .cnt_o (cycle_cnt_o)
    );

    rvga_perf_counter #(.CNT_W(CNT_W)) u_instret_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (retire_v_o),
        .cnt_o (instret_cnt_o)
    );

    rvga_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (stall_v_o[0] & (state_q == PIPE_RUN)),
        .cnt_o (stall_cnt_o)
    );

endmodule

// File: tb/tb_rvga_pipe_ctrl.sv
// Self-checking bench for rvga_pipe_ctrl: directed scenarios plus randomized
// stimulus against a behavioural model; a second CNT_W=8 instance checks wrap.
module tb_rvga_pipe_ctrl;

    localparam int S = 6;
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2, M_STEP = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, imem_req, imem_resp, dmem_req, dmem_resp, btaken, halt, step;
    logic [S-1:0] sv, br;
    logic [S-1:0] stall_o, flush_o, stall8_o, flush8_o;
    logic         retire_o, halted_o, retire8_o, halted8_o;
    logic [31:0]  cyc_o, ret_o, stl_o;
    logic [7:0]   cyc8_o, ret8_o, stl8_o;

    rvga_pipe_ctrl #(.STAGES(S), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .imem_req_v_i(imem_req), .imem_resp_v_i(imem_resp),
        .dmem_req_v_i(dmem_req), .dmem_resp_v_i(dmem_resp), .stage_v_i(sv), .br_v_i(br),
        .btaken_i(btaken), .dbg_halt_i(halt), .dbg_step_i(step),
        .stall_v_o(stall_o), .flush_v_o(flush_o), .retire_v_o(retire_o), .halted_o(halted_o),
        .cycle_cnt_o(cyc_o), .instret_cnt_o(ret_o), .stall_cnt_o(stl_o)
    );

    rvga_pipe_ctrl #(.STAGES(S), .CNT_W(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .imem_req_v_i(imem_req), .imem_resp_v_i(imem_resp),
        .dmem_req_v_i(dmem_req), .dmem_resp_v_i(dmem_resp), .stage_v_i(sv), .br_v_i(br),
        .btaken_i(btaken), .dbg_halt_i(halt), .dbg_step_i(step),
        .stall_v_o(stall8_o), .flush_v_o(flush8_o), .retire_v_o(retire8_o), .halted_o(halted8_o),
        .cycle_cnt_o(cyc8_o), .instret_cnt_o(ret8_o), .stall_cnt_o(stl8_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int           mode = M_RUN;
    bit           m_halted = 1'b0;
    longint       m_cyc = 0, m_ret = 0, m_stl = 0;
    logic [S-1:0] e_stall, e_flush;
    logic         e_ret;

    task automatic set_idle();
        imem_req = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
        btaken = 1'b0; halt = 1'b0; step = 1'b0; sv = '0; br = '0;
    endtask

    // Wait to mid-cycle and derive expected combinational outputs from the rules.
    task automatic settle();
        bit dw, iw, red, bp, hold;
        @(negedge clk);
        dw   = dmem_req && !dmem_resp;
        iw   = imem_req && !imem_resp;
        red  = btaken && !dw;
        bp   = (br[S-1:1] & sv[S-1:1]) != 0;
        hold = iw || bp || (mode != M_RUN && mode != M_STEP);
        e_stall = '0;
        e_flush = '0;
        if (rst)       e_flush = '1;
        else if (dw)   e_stall = '1;
        else if (red)  e_flush = {S{1'b1}} >> 1;
        else if (hold) begin e_stall = 6'h01; e_flush = 6'h02; end
        e_ret = !rst && sv[S-1] && !e_stall[S-1];
    endtask

    // Advance the model across the coming clock edge, then step past it.
    task automatic advance();
        if (rst) begin
            mode = M_RUN; m_cyc = 0; m_ret = 0; m_stl = 0;
        end else begin
            m_cyc++;
            if (e_ret) m_ret++;
            if (e_stall[0] && mode == M_RUN) m_stl++;
            case (mode)
                M_RUN:    if (halt) mode = M_DRAIN;
                M_DRAIN:  if (sv[S-1:1] == 0) mode = M_HALTED;
                M_HALTED: if (!halt) mode = M_RUN; else if (step) mode = M_STEP;
                M_STEP:   if (imem_resp && !e_stall[0]) mode = M_DRAIN;
                default:  mode = M_RUN;
            endcase
        end
        m_halted = (mode == M_HALTED);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_idle(); rst = 1'b1;
        settle();
        n_cmp++; if (stall_o !== 6'h00) begin n_bad++; $display("FAIL rst_stall: got %h want 00", stall_o); end
        n_cmp++; if (flush_o !== 6'h3F) begin n_bad++; $display("FAIL rst_flush: got %h want 3f", flush_o); end
        n_cmp++; if (retire_o !== 1'b0) begin n_bad++; $display("FAIL rst_retire: got %b want 0", retire_o); end
        advance(); settle(); advance();
        rst = 1'b0;
        settle();
        n_cmp++; if (cyc_o !== 32'd0) begin n_bad++; $display("FAIL rst_cycle: got %0d want 0", cyc_o); end
        n_cmp++; if (halted_o !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %b want 0", halted_o); end
        advance();
        for (int i = 0; i < 9; i++) begin settle(); advance(); end
        settle();
        n_cmp++; if (cyc_o !== 32'd10) begin n_bad++; $display("FAIL idle_cycle: got %0d want 10", cyc_o); end
        n_cmp++; if (ret_o !== 32'd0) begin n_bad++; $display("FAIL idle_instret: got %0d want 0", ret_o); end
        n_cmp++; if ({stall_o, flush_o} !== 12'h000) begin n_bad++; $display("FAIL idle_vec: got %h/%h want 00/00", stall_o, flush_o); end
        advance();
    endtask

    task automatic test_dmem_stall();
        longint ret0;
        set_idle(); sv = 6'h20; dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_cmp++; if (stall_o !== 6'h3F) begin n_bad++; $display("FAIL dwait_stall[%0d]: got %h want 3f", i, stall_o); end
            n_cmp++; if (retire_o !== 1'b0) begin n_bad++; $display("FAIL dwait_retire[%0d]: got %b want 0", i, retire_o); end
            advance();
        end
        dmem_resp = 1'b1;
        settle();
        n_cmp++; if (retire_o !== 1'b1) begin n_bad++; $display("FAIL dresp_retire: got %b want 1", retire_o); end
        n_cmp++; if (stl_o !== 32'd3) begin n_bad++; $display("FAIL dwait_stallcnt: got %0d want 3", stl_o); end
        ret0 = m_ret;
        advance();
        set_idle();
        settle();
        n_cmp++; if (ret_o !== 32'(ret0 + 1)) begin n_bad++; $display("FAIL dresp_instret: got %0d want %0d", ret_o, ret0 + 1); end
        advance();
    endtask

    task automatic test_branch();
        set_idle(); br = 6'h04; sv = 6'h04;
        settle();
        n_cmp++; if ({stall_o, flush_o} !== {6'h01, 6'h02}) begin n_bad++; $display("FAIL brpend: got %h/%h want 01/02", stall_o, flush_o); end
        advance();
        btaken = 1'b1; sv = 6'h24;
        settle();
        n_cmp++; if ({stall_o, flush_o} !== {6'h00, 6'h1F}) begin n_bad++; $display("FAIL redirect: got %h/%h want 00/1f", stall_o, flush_o); end
        advance();
        dmem_req = 1'b1;
        settle();
        n_cmp++; if ({stall_o, flush_o} !== {6'h3F, 6'h00}) begin n_bad++; $display("FAIL redirect_dwait: got %h/%h want 3f/00", stall_o, flush_o); end
        advance();
        set_idle();
    endtask

    task automatic test_debug();
        logic [S-1:0] seq [4] = '{6'h3C, 6'h38, 6'h30, 6'h20};
        set_idle(); halt = 1'b1; sv = 6'h3E;
        settle(); advance();
        for (int i = 0; i < 4; i++) begin
            sv = seq[i];
            settle();
            n_cmp++; if ({stall_o, flush_o} !== {6'h01, 6'h02}) begin n_bad++; $display("FAIL drain_hold[%0d]: got %h/%h want 01/02", i, stall_o, flush_o); end
            n_cmp++; if (halted_o !== 1'b0) begin n_bad++; $display("FAIL drain_halted[%0d]: got %b want 0", i, halted_o); end
            advance();
        end
        sv = 6'h00;
        settle();
        n_cmp++; if (halted_o !== 1'b0) begin n_bad++; $display("FAIL empty_halted: got %b want 0", halted_o); end
        advance();
        settle();
        n_cmp++; if (halted_o !== 1'b1) begin n_bad++; $display("FAIL halted_rise: got %b want 1", halted_o); end
        step = 1'b1;
        advance();
        step = 1'b0; imem_req = 1'b1;
        settle();
        n_cmp++; if (halted_o !== 1'b0) begin n_bad++; $display("FAIL step_halted: got %b want 0", halted_o); end
        n_cmp++; if (stall_o !== 6'h01) begin n_bad++; $display("FAIL step_iwait: got %h want 01", stall_o); end
        advance();
        imem_resp = 1'b1;
        settle();
        n_cmp++; if (stall_o !== 6'h00) begin n_bad++; $display("FAIL step_fetch: got %h want 00", stall_o); end
        advance();
        imem_req = 1'b0; imem_resp = 1'b1; sv = 6'h02;
        settle();
        n_cmp++; if (stall_o !== 6'h01) begin n_bad++; $display("FAIL step_onefetch: got %h want 01", stall_o); end
        advance();
        imem_resp = 1'b0; sv = 6'h00;
        settle(); advance();
        settle();
        n_cmp++; if (halted_o !== 1'b1) begin n_bad++; $display("FAIL step_rehalt: got %b want 1", halted_o); end
        halt = 1'b0;
        advance();
        settle();
        n_cmp++; if ({halted_o, stall_o} !== 7'h00) begin n_bad++; $display("FAIL release: got %b/%h want 0/00", halted_o, stall_o); end
        advance();
    endtask

    task automatic test_reset_mid_step();
        set_idle(); halt = 1'b1;
        settle(); advance(); settle(); advance();
        step = 1'b1;
        settle(); advance();
        step = 1'b0; rst = 1'b1;
        settle();
        n_cmp++; if ({stall_o, flush_o} !== {6'h00, 6'h3F}) begin n_bad++; $display("FAIL step_rst_vec: got %h/%h want 00/3f", stall_o, flush_o); end
        advance();
        rst = 1'b0; halt = 1'b0;
        settle();
        n_cmp++; if ({halted_o, stall_o} !== 7'h00) begin n_bad++; $display("FAIL step_rst_run: got %b/%h want 0/00", halted_o, stall_o); end
        n_cmp++; if ({cyc_o, ret_o, stl_o} !== 96'h0) begin n_bad++; $display("FAIL step_rst_cnt: got %0d/%0d/%0d want 0/0/0", cyc_o, ret_o, stl_o); end
        advance();
    endtask

    task automatic test_wrap();
        set_idle(); rst = 1'b1;
        settle(); advance();
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin settle(); advance(); end
        settle();
        n_cmp++; if (cyc8_o !== 8'd44) begin n_bad++; $display("FAIL wrap8: got %0d want 44", cyc8_o); end
        n_cmp++; if (cyc_o !== 32'd300) begin n_bad++; $display("FAIL wrap32: got %0d want 300", cyc_o); end
        advance();
    endtask

    task automatic test_random();
        set_idle();
        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(0, 149) == 0);
            imem_req  = $urandom_range(0, 1) != 0;
            imem_resp = $urandom_range(0, 1) != 0;
            dmem_req  = $urandom_range(0, 3) == 0;
            dmem_resp = $urandom_range(0, 1) != 0;
            btaken    = $urandom_range(0, 4) == 0;
            step      = $urandom_range(0, 4) == 0;
            if ($urandom_range(0, 19) == 0) halt = ~halt;
            sv = S'($urandom);
            br = S'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 3) == 0) sv = sv & 6'h21;
            settle();
            n_cmp++; if (stall_o !== e_stall) begin n_bad++; $display("FAIL rnd_stall@%0d: got %h want %h", i, stall_o, e_stall); end
            n_cmp++; if (flush_o !== e_flush) begin n_bad++; $display("FAIL rnd_flush@%0d: got %h want %h", i, flush_o, e_flush); end
            n_cmp++; if (retire_o !== e_ret) begin n_bad++; $display("FAIL rnd_retire@%0d: got %b want %b", i, retire_o, e_ret); end
            n_cmp++; if (halted_o !== m_halted) begin n_bad++; $display("FAIL rnd_halted@%0d: got %b want %b", i, halted_o, m_halted); end
            n_cmp++; if (cyc_o !== m_cyc[31:0]) begin n_bad++; $display("FAIL rnd_cycle@%0d: got %0d want %0d", i, cyc_o, m_cyc[31:0]); end
            n_cmp++; if (ret_o !== m_ret[31:0]) begin n_bad++; $display("FAIL rnd_instret@%0d: got %0d want %0d", i, ret_o, m_ret[31:0]); end
            n_cmp++; if (stl_o !== m_stl[31:0]) begin n_bad++; $display("FAIL rnd_stallcnt@%0d: got %0d want %0d", i, stl_o, m_stl[31:0]); end
            n_cmp++; if ({stall8_o, flush8_o, retire8_o, halted8_o} !== {e_stall, e_flush, e_ret, m_halted})
                begin n_bad++; $display("FAIL rnd_w8_vec@%0d: got %h/%h/%b/%b", i, stall8_o, flush8_o, retire8_o, halted8_o); end
            n_cmp++; if ({cyc8_o, ret8_o, stl8_o} !== {m_cyc[7:0], m_ret[7:0], m_stl[7:0]})
                begin n_bad++; $display("FAIL rnd_w8_cnt@%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i, cyc8_o, ret8_o, stl8_o, m_cyc[7:0], m_ret[7:0], m_stl[7:0]); end
            advance();
        end
        set_idle();
    endtask

    initial begin
        set_idle(); rst = 1'b1;
        #1;
        test_reset();
        test_dmem_stall();
        test_branch();
        test_debug();
        test_reset_mid_step();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
